// File: rtl/dilithium_pkg.sv
// ============================================================================
// Module      : dilithium_pkg
// Description : Shared Dilithium constants and reduction mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dilithium_pkg;

  localparam logic signed [31:0] c_q         = 32'sd8380417;
  localparam logic signed [31:0] c_round     = 32'sd4194304;
  localparam int                 c_n_default = 256;

  typedef enum logic [1:0] {
    MODE_CADDQ    = 2'd0,
    MODE_REDUCE32 = 2'd1,
    MODE_FREEZE   = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/coeff_reduce.sv
// ============================================================================
// Module      : coeff_reduce
// Description : Per-coefficient reduction; stage 0 = REDUCE32, stage 1 = CADDQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coeff_reduce
  import dilithium_pkg::*;
(
  input  logic [31:0] a,
  input  logic [1:0]  mode,
  input  logic        stage,
  output logic [31:0] r
);

  logic signed [31:0] w_a;
  logic signed [31:0] w_t;
  logic signed [31:0] w_red;
  logic signed [31:0] w_cadd;
  logic               w_do_red;
  logic               w_do_cadd;

  always_comb begin
    w_a       = a;
    w_t       = (w_a + c_round) >>> 23;
    w_red     = w_a - w_t * c_q;
    w_cadd    = w_a + (w_a[31] ? c_q : 32'sd0);
    w_do_red  = (mode == MODE_REDUCE32) || (mode == MODE_FREEZE);
    // Reserved encoding falls through to the conditional add.
    w_do_cadd = (mode != MODE_REDUCE32);
    if (stage) begin
      r = w_do_cadd ? w_cadd : a;
    end else begin
      r = w_do_red ? w_red : a;
    end
  end

endmodule

`default_nettype wire

// File: rtl/poly_reduce_stream.sv
// ============================================================================
// Module      : poly_reduce_stream
// Description : Two-stage streaming polynomial reducer (REDUCE32 -> CADDQ).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module poly_reduce_stream
  import dilithium_pkg::*;
#(
  parameter int LANES = 8,
  parameter int N     = c_n_default
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int BEATS = N / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]      r_beat_cnt;
  logic [1:0]            r_mode;
  logic                  r_s1_valid;
  logic                  r_s1_last;
  logic [1:0]            r_s1_mode;
  logic [32*LANES-1:0]   r_s1_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [32*LANES-1:0]   r_out_data;

  logic                  w_advance;
  logic                  w_accept;
  logic                  w_is_last;
  logic [1:0]            w_beat_mode;
  logic [32*LANES-1:0]   w_s1_next;
  logic [32*LANES-1:0]   w_s2_next;

  assign w_advance   = !r_out_valid || out_ready;
  assign w_accept    = in_valid && w_advance;
  assign w_is_last   = (r_beat_cnt == C_LAST_BEAT);
  // Beat 0 sees the live mode; later beats use the copy latched at beat 0.
  assign w_beat_mode = (r_beat_cnt == '0) ? mode : r_mode;

  assign in_ready  = w_advance;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign busy      = (r_beat_cnt != '0) || r_s1_valid || r_out_valid;

  for (genvar k = 0; k < LANES; k++) begin : g_lanes
    coeff_reduce u_stage1 (
      .a     (in_data[32*k +: 32]),
      .mode  (w_beat_mode),
      .stage (1'b0),
      .r     (w_s1_next[32*k +: 32])
    );
    coeff_reduce u_stage2 (
      .a     (r_s1_data[32*k +: 32]),
      .mode  (r_s1_mode),
      .stage (1'b1),
      .r     (w_s2_next[32*k +: 32])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_mode      <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_mode   <= '0;
      r_s1_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_accept) begin
        r_beat_cnt <= w_is_last ? '0 : r_beat_cnt + 1'b1;
        if (r_beat_cnt == '0) begin
          r_mode <= mode;
        end
      end
      // Whole pipeline moves together; an empty input slot becomes a bubble.
      if (w_advance) begin
        r_s1_valid  <= w_accept;
        r_s1_last   <= w_accept && w_is_last;
        r_s1_mode   <= w_beat_mode;
        r_s1_data   <= w_s1_next;
        r_out_valid <= r_s1_valid;
        r_out_last  <= r_s1_last;
        r_out_data  <= w_s2_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/poly_reduce_stream.md
POLY_REDUCE_STREAM -- requirements
Module: poly_reduce_stream

Interface
REQ-001 SHALL have parameter LANES, default 8, coefficients processed per beat; legal values 1, 2, 4, 8, 16, 32, 64, 128, 256.
REQ-002 SHALL have parameter N, default 256, coefficients per polynomial.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-004 SHALL have port mode, input, 2 bits: 0 CADDQ, 1 REDUCE32, 2 FREEZE, 3 reserved (treated as CADDQ).
REQ-005 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-006 SHALL have port in_ready, output, 1 bit: input beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data, input, 32*LANES bits: signed 32-bit coefficients, lane k at bits [32k+31:32k].
REQ-008 SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-010 SHALL have port out_data, output, 32*LANES bits: reduced coefficients, same lane packing as in_data.
REQ-011 SHALL have port out_last, output, 1 bit: final beat of a polynomial.
REQ-012 SHALL have port busy, output, 1 bit: polynomial partially accepted or data in the pipeline.

Function
REQ-013 SHALL compute CADDQ per lane as a + (Q if a < 0 else 0), where Q = 8380417, in 32-bit arithmetic.
REQ-014 SHALL compute REDUCE32 per lane as t = (a + 2^22) >>> 23 (arithmetic shift), r = a - t*Q, truncated to 32 bits; inputs above 2^31 - 2^22 - 1 are outside the contract.
REQ-015 SHALL compute FREEZE per lane as CADDQ(REDUCE32(a)).
REQ-016 SHALL register REDUCE32 in stage 1 and CADDQ in stage 2; CADDQ mode bypasses the reduction in stage 1, and REDUCE32 mode bypasses the add in stage 2.
REQ-017 SHALL have a fixed latency of 2 cycles from input acceptance to out_valid when unstalled, with a throughput of one beat per cycle.
REQ-018 SHALL derive advance = !out_valid || out_ready and in_ready = advance (combinational); all stages shift only on advance, and bubbles propagate.
REQ-019 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-020 SHALL count accepted beats in beat_cnt, 0..N/LANES-1, wrapping to 0 after the final beat; the final beat carries last=1 down the pipeline to out_last.
REQ-021 SHALL latch mode on acceptance of beat 0 only; changes to mode mid-polynomial are ignored; each pipeline stage carries its own copy of the mode.
REQ-022 SHALL, for LANES = N, assert out_last on every beat.
REQ-023 SHALL assert busy when beat_cnt != 0 or either stage valid is set.
REQ-024 SHALL, on consecutive polynomials, accept beat 0 of the next polynomial in the cycle after the previous final beat is accepted, with no bubble.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear the stage valids, beat_cnt, latched mode, out_valid, out_last and busy to 0; out_data is reset to 0.
REQ-026 SHALL discard any partially processed polynomial on reset mid-operation; the first beat accepted after reset is beat 0.
REQ-027 SHALL drive in_ready = 1 on the first clock after reset release.

Structure
REQ-028 SHALL take Q, N default, mode encodings and the 2^22 rounding constant from shared package dilithium_pkg.
REQ-029 SHALL instantiate per lane one combinational sub-module coeff_reduce (inputs: a, mode, stage select); the pipeline registers, counter and handshake live in poly_reduce_stream.

Verification
REQ-030 SHALL check: CADDQ with all lanes = -1 (0xFFFFFFFF) -> all lanes 8380416, out_valid 2 cycles later.
REQ-031 SHALL check: REDUCE32 with lanes {8380417, -8380417, 4194304, 0} -> {0, 0, -4186113, 0}.
REQ-032 SHALL check: FREEZE with lanes {8380418, -1, 16760834, 2^31-2^22-1} -> {1, 8380416, 0, canonical value in [0, Q-1]}.
REQ-033 SHALL check: LANES=8 stream of 32 beats with random out_ready stalls -> exactly 32 output beats in order, out_last only on the 32nd, data stable during stalls.
REQ-034 SHALL check: mode toggled at beat 5 of a polynomial -> the whole polynomial uses the beat-0 mode; the next polynomial uses the new mode.
REQ-035 SHALL check: rst_n pulsed low at beat 10 -> out_valid=0 and busy=0 immediately; the next accepted beat is treated as beat 0 (out_last after 32 more beats).
